// File: rtl/lc3b_pkg.sv
// Shared LC-3b field slices, the BR opcode and the branch-unit state encoding.
// Field helpers keep the instruction-format knowledge in one place.
package lc3b_pkg;

    localparam logic [3:0] OP_BR = 4'b0000;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned NZP_MSB  = 11;
    localparam int unsigned NZP_LSB  = 9;
    localparam int unsigned OFF9_MSB = 8;
    localparam int unsigned OFF9_LSB = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_CC = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        WAIT_CC = ST_WAIT_CC,
        RESP    = ST_RESP
    } br_state_t;

    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] ir_nzp(input logic [15:0] ir);
        return ir[NZP_MSB:NZP_LSB];
    endfunction

    function automatic logic [8:0] ir_off9(input logic [15:0] ir);
        return ir[OFF9_MSB:OFF9_LSB];
    endfunction

endpackage

// File: rtl/br_eval.sv
// Combinational BR resolution: nzp match against the flags, and
// target = pc + (sext(PCoffset) << 1) modulo 2^ADDR_W.
module br_eval
    import lc3b_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned OFF_W  = 9
) (
    input  logic [15:0]       ir_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              n_i,
    input  logic              z_i,
    input  logic              p_i,
    output logic              taken_o,
    output logic              illegal_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [2:0]        nzp;
    logic [ADDR_W-1:0] off_sext;

    always_comb begin
        nzp       = ir_nzp(ir_i);
        off_sext  = {{(ADDR_W-OFF_W){ir_i[OFF_W-1]}}, ir_i[OFF_W-1:0]};
        target_o  = pc_i + (off_sext << 1);
        illegal_o = (ir_opcode(ir_i) != OP_BR);
        // A non-BR opcode never redirects fetch, whatever its bits 11:9 hold.
        taken_o   = !illegal_o && ((nzp[2] & n_i) | (nzp[1] & z_i) | (nzp[0] & p_i));
    end

endmodule

// File: rtl/br_cond_unit.sv
// LC-3b branch resolution unit: accepts a BR, waits out CC writes, and
// returns a registered taken/target decision plus retirement statistics.
module br_cond_unit
    import lc3b_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned OFF_W  = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_ir,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              cc_n,
    input  logic              cc_z,
    input  logic              cc_p,
    input  logic              cc_ld,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_taken,
    output logic              rsp_illegal,
    output logic [ADDR_W-1:0] rsp_target,
    output logic [ADDR_W-1:0] rsp_next_pc,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    br_state_t         state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic [15:0]       ev_ir;
    logic [ADDR_W-1:0] ev_pc;
    logic              ev_taken, ev_illegal;
    logic [ADDR_W-1:0] ev_target;
    logic              load_rsp;

    // In IDLE the request is evaluated straight off the bus; after a stall it comes from the capture.
    assign ev_ir = (state_q == IDLE) ? req_ir : ir_q;
    assign ev_pc = (state_q == IDLE) ? req_pc : pc_q;

    br_eval #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_eval (
        .ir_i      (ev_ir),
        .pc_i      (ev_pc),
        .n_i       (cc_n),
        .z_i       (cc_z),
        .p_i       (cc_p),
        .taken_o   (ev_taken),
        .illegal_o (ev_illegal),
        .target_o  (ev_target)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        load_rsp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ir_d    = req_ir;
                    pc_d    = req_pc;
                    load_rsp = !cc_ld;
                    state_d  = cc_ld ? WAIT_CC : RESP;
                end
            end
            WAIT_CC: begin
                if (!cc_ld) begin
                    load_rsp = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (!illegal_q) begin
                        br_cnt_d    = br_cnt_q + 1'b1;
                        taken_cnt_d = taken_cnt_q + CNT_W'(taken_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        taken_d   = taken_q;
        illegal_d = illegal_q;
        target_d  = target_q;
        next_pc_d = next_pc_q;
        if (load_rsp) begin
            taken_d   = ev_taken;
            illegal_d = ev_illegal;
            target_d  = ev_target;
            next_pc_d = ev_taken ? ev_target : ev_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            target_q    <= '0;
            next_pc_q   <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
            target_q    <= target_d;
            next_pc_q   <= next_pc_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;
    assign rsp_target  = target_q;
    assign rsp_next_pc = next_pc_q;
    assign br_cnt      = br_cnt_q;
    assign taken_cnt   = taken_cnt_q;

endmodule
